// File: rtl/tinker_pkg.sv
// Shared types for the Tinker core memory-port arbiter.
package tinker_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_LS = 1'b1
   } req_id_t;

   localparam int unsigned MEM_LAT_MAX = 15;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between fetch and load/store requesters.
// Tie rule: round robin when ARB_ROUND_ROBIN_EN is defined, else load/store priority.
module arb_pick
   import tinker_pkg::*;
(
   input  logic    if_req,
   input  logic    ls_req,
   input  req_id_t last_id,
   output req_id_t winner
);

`ifdef ARB_ROUND_ROBIN_EN
`else
   logic unused_last_id;
   assign unused_last_id = last_id;
`endif

   always_comb begin
      winner = REQ_IF;
      if (if_req && ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         winner = (last_id == REQ_IF) ? REQ_LS : REQ_IF;
`else
         winner = REQ_LS;
`endif
      end else if (ls_req) begin
         winner = REQ_LS;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory between instruction fetch and load/store requesters.
// Optional round-robin tie rule via the ARB_ROUND_ROBIN_EN macro.
module mem_port_arbiter
   import tinker_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned ADDR_W  = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [63:0]       ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [63:0]       ls_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   input  logic [63:0]       mem_rdata,
   output logic              busy
);

   localparam int unsigned CntW = $clog2(MEM_LAT + 1);

   arb_state_t     state_q;
   logic [CntW-1:0] cnt_q;
   req_id_t        id_q;
   logic           we_q;
   req_id_t        last_id;
   req_id_t        winner;

   arb_pick u_arb_pick (
      .if_req  (if_req),
      .ls_req  (ls_req),
      .last_id (last_id),
      .winner  (winner)
   );

`ifdef ARB_ROUND_ROBIN_EN
   req_id_t last_q;
   assign last_id = last_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_q <= REQ_IF;
      end else if (state_q == ARB_IDLE && (if_req || ls_req)) begin
         last_q <= winner;
      end
   end
`else
   assign last_id = REQ_IF;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ARB_IDLE;
         cnt_q     <= '0;
         id_q      <= REQ_IF;
         we_q      <= 1'b0;
         if_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         if_rdata  <= '0;
         ls_gnt    <= 1'b0;
         ls_rvalid <= 1'b0;
         ls_rdata  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         unique case (state_q)
            ARB_IDLE: begin
               if (if_req || ls_req) begin
                  state_q <= ARB_BUSY;
                  busy    <= 1'b1;
                  id_q    <= winner;
                  cnt_q   <= CntW'(MEM_LAT - 1);
                  mem_en  <= 1'b1;
                  if (winner == REQ_LS) begin
                     mem_addr  <= ls_addr;
                     mem_wdata <= ls_wdata;
                     mem_we    <= ls_we;
                     we_q      <= ls_we;
                     ls_gnt    <= 1'b1;
                  end else begin
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                     mem_we    <= 1'b0;
                     we_q      <= 1'b0;
                     if_gnt    <= 1'b1;
                  end
               end
            end
            ARB_BUSY: begin
               // Grant and write strobe live only in the first BUSY cycle.
               if_gnt <= 1'b0;
               ls_gnt <= 1'b0;
               mem_we <= 1'b0;
               if (cnt_q == '0) begin
                  state_q <= ARB_RESP;
                  mem_en  <= 1'b0;
                  if (id_q == REQ_LS) begin
                     ls_rvalid <= 1'b1;
                     ls_rdata  <= we_q ? 64'd0 : mem_rdata;
                  end else begin
                     if_rvalid <= 1'b1;
                     if_rdata  <= mem_rdata[31:0];
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ARB_RESP: begin
               state_q   <= ARB_IDLE;
               busy      <= 1'b0;
               if_rvalid <= 1'b0;
               ls_rvalid <= 1'b0;
            end
            default: begin
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule
